fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode_pkg.sv | 32 +++
 rtl/fetch_decode_regfile.sv | 38 +++
 rtl/fetch_decode.sv | 86 ++++++++
 tb/tb_fetch_decode.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared types and constants for the fetch/decode slice.
// State encoding, register-field positions, RF size.
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    S_IF = 2'd0,
    S_ID = 2'd1,
    S_EX = 2'd2,
    S_WB = 2'd3
  } state_t;

  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  function automatic logic [RF_AW-1:0] rs_of(
    input logic [31:0] i
  );
    return i[RS_HI:RS_LO];
  endfunction

  function automatic logic [RF_AW-1:0] rt_of(
    input logic [31:0] i
  );
    return i[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/fetch_decode_regfile.sv
// 32x32 register file, two async read ports, one write.
// Register 0 is hard-wired to zero.
module regfile
  import fetch_decode_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [RF_AW-1:0] raddr1,
  input  logic [RF_AW-1:0] raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2
);

  logic [31:0] mem [RF_DEPTH];

  // storage: cleared on reset, r0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // read ports: index 0 forced to zero
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = mem[raddr1];
    if (raddr2 != '0) rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/fetch_decode.sv
// Four-phase fetch/decode sequencer: FSM, PC, IR, icount.
// One instruction retires every four cycles.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int IM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  output logic [31:0]      ins,
  output logic [31:0]      pc,
  output logic [31:0]      reg1,
  output logic [31:0]      reg2,
  input  logic [RF_AW-1:0] wra,
  input  logic [31:0]      result,
  input  logic [31:0]      nextpc,
  output logic             ex_phase,
  output logic [31:0]      icount
);

  state_t      state;
  logic        we;
  logic [31:0] rd1;
  logic [31:0] rd2;

  // ROM address follows pc in every state
  assign im_addr = pc[IM_AW-1:0];

  // write-back only on the WB->IF edge, never to r0
  assign we = (state == S_WB) && (wra != '0);

  regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (wra),
    .wdata  (result),
    .raddr1 (rs_of(im_data)),
    .raddr2 (rt_of(im_data)),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // sequencer with registered IR, operands, pc, icount
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IF;
      pc       <= '0;
      ins      <= '0;
      reg1     <= '0;
      reg2     <= '0;
      icount   <= '0;
      ex_phase <= 1'b0;
    end else begin
      unique case (state)
        S_IF: begin
          if (run) state <= S_ID;
        end
        S_ID: begin
          state    <= S_EX;
          ins      <= im_data;
          reg1     <= rd1;
          reg2     <= rd2;
          ex_phase <= 1'b1;
        end
        S_EX: begin
          state    <= S_WB;
          ex_phase <= 1'b0;
        end
        S_WB: begin
          state  <= S_IF;
          pc     <= nextpc;
          icount <= icount + 32'd1;
        end
        default: begin
          state    <= S_IF;
          ex_phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode.
// Instruction-level model of pc, icount and register file.
module tb_fetch_decode;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_data;
  logic [31:0]   ins;
  logic [31:0]   pc;
  logic [31:0]   reg1;
  logic [31:0]   reg2;
  logic [4:0]    wra;
  logic [31:0]   result;
  logic [31:0]   nextpc;
  logic          ex_phase;
  logic [31:0]   icount;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom  [1<<AW];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [31:0] m_icount;

  fetch_decode #(.IM_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .im_addr  (im_addr),
    .im_data  (im_data),
    .ins      (ins),
    .pc       (pc),
    .reg1     (reg1),
    .reg2     (reg2),
    .wra      (wra),
    .result   (result),
    .nextpc   (nextpc),
    .ex_phase (ex_phase),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_data <= rom[im_addr];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc     = '0;
    m_icount = '0;
  endtask

  // one full instruction with a given execute outcome
  task automatic do_instr(
    input  logic [4:0]  w,
    input  logic [31:0] r,
    input  logic [31:0] np,
    output logic [31:0] seen_r1
  );
    logic [31:0] e_ins;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [7:0]  a;
    bit          seen;
    a       = m_pc[AW-1:0];
    e_ins   = rom[a];
    e_r1    = m_rf[e_ins[25:21]];
    e_r2    = m_rf[e_ins[20:16]];
    seen_r1 = 'x;
    run = 1'b1;
    @(negedge clk);
    run  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (!seen) begin
        @(negedge clk);
        seen = ex_phase;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ex_wait ex_phase=%b want 1", ex_phase);
      return;
    end
    seen_r1 = reg1;
    checks += 4;
    if (ins !== e_ins) begin
      errors++;
      $display("FAIL ins got %h want %h", ins, e_ins);
    end
    if (pc !== m_pc) begin
      errors++;
      $display("FAIL ex_pc got %h want %h", pc, m_pc);
    end
    if (reg1 !== e_r1) begin
      errors++;
      $display("FAIL reg1 got %h want %h", reg1, e_r1);
    end
    if (reg2 !== e_r2) begin
      errors++;
      $display("FAIL reg2 got %h want %h", reg2, e_r2);
    end
    wra    = w;
    result = r;
    nextpc = np;
    @(negedge clk);
    checks += 2;
    if (ex_phase !== 1'b0) begin
      errors++;
      $display("FAIL wb_ex_phase got %b want 0", ex_phase);
    end
    if (reg1 !== e_r1 || ins !== e_ins) begin
      errors++;
      $display("FAIL wb_hold reg1 %h ins %h want %h %h",
               reg1, ins, e_r1, e_ins);
    end
    @(negedge clk);
    if (w != 5'd0) m_rf[w] = r;
    m_pc     = np;
    m_icount = m_icount + 32'd1;
    checks += 3;
    if (pc !== m_pc) begin
      errors++;
      $display("FAIL wb_pc got %h want %h", pc, m_pc);
    end
    if (icount !== m_icount) begin
      errors++;
      $display("FAIL icount got %h want %h", icount, m_icount);
    end
    if (im_addr !== m_pc[AW-1:0]) begin
      errors++;
      $display("FAIL im_addr got %h want %h",
               im_addr, m_pc[AW-1:0]);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    run    = 1'b0;
    wra    = '0;
    result = '0;
    nextpc = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (pc !== 0 || icount !== 0) begin
      errors++;
      $display("FAIL rst_cnt pc %h icount %h want 0", pc, icount);
    end
    if (ins !== 0 || reg1 !== 0 || reg2 !== 0) begin
      errors++;
      $display("FAIL rst_regs %h %h %h want 0", ins, reg1, reg2);
    end
    if (ex_phase !== 1'b0) begin
      errors++;
      $display("FAIL rst_ex got %b want 0", ex_phase);
    end
    if (im_addr !== '0) begin
      errors++;
      $display("FAIL rst_addr got %h want 0", im_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_instr();
    logic [31:0] v;
    do_instr(5'd1, 32'd5, 32'd1, v);
    checks++;
    if (pc !== 32'd1 || icount !== 32'd1) begin
      errors++;
      $display("FAIL first pc %h icount %h want 1 1", pc, icount);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    do_instr(5'd2, 32'h0000000a, 32'd2, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("FAIL b2b_reg1 got %h want 5", v);
    end
  endtask

  task automatic test_r0();
    logic [31:0] v;
    do_instr(5'd0, 32'hdeadbeef, 32'd3, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL r0_read got %h want 0", v);
    end
    do_instr(5'd0, 32'h0, 32'd4, v);
    checks++;
    if (v !== 32'd0 || reg2 !== 32'd5) begin
      errors++;
      $display("FAIL r0_nowrite r0 %h r1 %h want 0 5", v, reg2);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] v;
    do_instr(5'd0, 32'h0, 32'h00000100, v);
    checks++;
    if (pc !== 32'h100 || im_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap pc %h addr %h want 100 00", pc, im_addr);
    end
  endtask

  task automatic test_hold();
    logic [31:0] v;
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pc !== m_pc || icount !== m_icount ||
          ex_phase !== 1'b0 || im_addr !== m_pc[AW-1:0]) begin
        errors++;
        $display("FAIL hold pc %h ic %h ex %b want %h %h 0",
                 pc, icount, ex_phase, m_pc, m_icount);
      end
    end
    do_instr(5'd4, 32'h44, m_pc + 32'd1, v);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    for (int k = 0; k < 60; k++) begin
      do_instr(5'($urandom_range(0, 31)), $urandom,
               (k % 4 == 0) ? $urandom : 32'($urandom_range(0, 15)),
               v);
    end
  endtask

  task automatic test_reset_in_ex();
    logic [31:0] v;
    bit          seen;
    do_instr(5'd3, 32'h77, m_pc + 32'd1, v);
    wra    = 5'd3;
    result = 32'h12345678;
    nextpc = 32'h55;
    run    = 1'b1;
    @(negedge clk);
    run  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (!seen) begin
        @(negedge clk);
        seen = ex_phase;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_ex_wait ex_phase=%b want 1", ex_phase);
    end
    rst = 1'b1;
    #1;
    checks += 2;
    if (pc !== 0 || icount !== 0 || ex_phase !== 1'b0) begin
      errors++;
      $display("FAIL abort pc %h ic %h ex %b want 0 0 0",
               pc, icount, ex_phase);
    end
    if (ins !== 0 || reg1 !== 0 || reg2 !== 0) begin
      errors++;
      $display("FAIL abort_regs %h %h %h want 0", ins, reg1, reg2);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rom[0] = 32'h00640000;
    @(negedge clk);
    do_instr(5'd0, 32'h0, 32'd1, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL abort_rf r3 got %h want 0", v);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    rom[0] = 32'h20010005;
    rom[1] = 32'h00221800;
    rom[2] = 32'h00001000;
    rom[3] = 32'h00010000;
    test_reset();
    test_first_instr();
    test_back_to_back();
    test_r0();
    test_pc_wrap();
    test_hold();
    test_random();
    test_reset_in_ex();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
